// File: rtl/cpu_module_mem.sv
// cpu_module_mem -- MEM stage of the 5-stage MIPS pipeline.
//   Holds the EX/MEM register, a word-addressed data memory (sw/lw) and the
//   MEM/WB register. The *_mem outputs feed 1-level forwarding and the hazard
//   unit; the *_wb outputs feed 2-level forwarding and register writeback.
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   ALUResult_ex ..          EX-stage results and control, latched each edge
//   Flush_mem                inserts a bubble into EX/MEM on the next edge
//   ALUResult_mem ..         registered EX/MEM values
//   RegWrite*_wb             registered MEM/WB writeback values
//   MisAlign                 current MEM-stage lw/sw is not word aligned
module cpu_module_mem #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ALUResult_ex,
  input  logic [31:0] MemWriteData_ex,
  input  logic [4:0]  RegWriteAddr_ex,
  input  logic        RegWrite_ex,
  input  logic        MemWrite_ex,
  input  logic        MemToReg_ex,
  input  logic        Flush_mem,
  output logic [31:0] ALUResult_mem,
  output logic [4:0]  RegWriteAddr_mem,
  output logic        RegWrite_mem,
  output logic        MemToReg_mem,
  output logic [4:0]  RegWriteAddr_wb,
  output logic        RegWrite_wb,
  output logic [31:0] RegWriteData_wb,
  output logic        MisAlign
);

  logic [31:0]       mem_wdata;
  logic              mem_write;
  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] idx;
  logic [31:0]       rdata;

  // EX/MEM register; a flush loads a full bubble (all fields zero).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ALUResult_mem    <= '0;
      mem_wdata        <= '0;
      RegWriteAddr_mem <= '0;
      RegWrite_mem     <= 1'b0;
      mem_write        <= 1'b0;
      MemToReg_mem     <= 1'b0;
    end else if (Flush_mem) begin
      ALUResult_mem    <= '0;
      mem_wdata        <= '0;
      RegWriteAddr_mem <= '0;
      RegWrite_mem     <= 1'b0;
      mem_write        <= 1'b0;
      MemToReg_mem     <= 1'b0;
    end else begin
      ALUResult_mem    <= ALUResult_ex;
      mem_wdata        <= MemWriteData_ex;
      RegWriteAddr_mem <= RegWriteAddr_ex;
      RegWrite_mem     <= RegWrite_ex;
      mem_write        <= MemWrite_ex;
      MemToReg_mem     <= MemToReg_ex;
    end
  end

  // Upper address bits are dropped so addresses wrap modulo DEPTH words.
  assign idx      = ALUResult_mem[ADDR_W+1:2];
  assign rdata    = mem[idx];
  assign MisAlign = (mem_write | MemToReg_mem) & (ALUResult_mem[1:0] != 2'b00);

  // Memory is deliberately not reset. A store in flight when rst rises is
  // dropped because mem_write clears asynchronously before its edge.
  always_ff @(posedge clk) begin
    if (mem_write && !MisAlign) mem[idx] <= mem_wdata;
  end

  // MEM/WB register; a misaligned load never writes the register file.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RegWriteAddr_wb <= '0;
      RegWrite_wb     <= 1'b0;
      RegWriteData_wb <= '0;
    end else begin
      RegWriteAddr_wb <= RegWriteAddr_mem;
      RegWrite_wb     <= RegWrite_mem & ~(MemToReg_mem & MisAlign);
      RegWriteData_wb <= MemToReg_mem ? rdata : ALUResult_mem;
    end
  end

endmodule

// File: tb/tb_cpu_module_mem.sv
module tb_cpu_module_mem;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ALUResult_ex, MemWriteData_ex;
  logic [4:0]  RegWriteAddr_ex;
  logic        RegWrite_ex, MemWrite_ex, MemToReg_ex, Flush_mem;
  logic [31:0] ALUResult_mem, RegWriteData_wb;
  logic [4:0]  RegWriteAddr_mem, RegWriteAddr_wb;
  logic        RegWrite_mem, MemToReg_mem, RegWrite_wb, MisAlign;

  int checks = 0;
  int errors = 0;

  cpu_module_mem #(.DEPTH(256), .ADDR_W(8)) dut (
    .clk(clk), .rst(rst),
    .ALUResult_ex(ALUResult_ex), .MemWriteData_ex(MemWriteData_ex),
    .RegWriteAddr_ex(RegWriteAddr_ex), .RegWrite_ex(RegWrite_ex),
    .MemWrite_ex(MemWrite_ex), .MemToReg_ex(MemToReg_ex), .Flush_mem(Flush_mem),
    .ALUResult_mem(ALUResult_mem), .RegWriteAddr_mem(RegWriteAddr_mem),
    .RegWrite_mem(RegWrite_mem), .MemToReg_mem(MemToReg_mem),
    .RegWriteAddr_wb(RegWriteAddr_wb), .RegWrite_wb(RegWrite_wb),
    .RegWriteData_wb(RegWriteData_wb), .MisAlign(MisAlign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Drive one EX-stage instruction.
  task automatic drv(input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] ra,
                     input logic rw, input logic mw, input logic m2r, input logic fl);
    ALUResult_ex = alu; MemWriteData_ex = wd; RegWriteAddr_ex = ra;
    RegWrite_ex = rw; MemWrite_ex = mw; MemToReg_ex = m2r; Flush_mem = fl;
  endtask

  task automatic idle();
    drv(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Load from addr into reg ra and check the writeback two edges later.
  task automatic load_chk(input string tag, input logic [31:0] addr, input logic [4:0] ra,
                          input logic [31:0] exp);
    drv(addr, 32'h0, ra, 1'b1, 1'b0, 1'b1, 1'b0); step();
    idle(); step();
    chk({tag, "_data"}, RegWriteData_wb, exp);
    chk({tag, "_we"}, {31'b0, RegWrite_wb}, 32'd1);
  endtask

  initial begin
    idle();
    rst = 1'b1;
    step(); step();
    chk("rst_alu_mem", ALUResult_mem, 32'h0);
    chk("rst_wb_data", RegWriteData_wb, 32'h0);
    chk("rst_flags", {28'b0, RegWrite_mem, MemToReg_mem, RegWrite_wb, MisAlign}, 32'h0);
    @(negedge clk); rst = 1'b0;

    // ALU passthrough
    drv(32'h0000_1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0); step();
    chk("pass_alu_mem", ALUResult_mem, 32'h1234);
    chk("pass_addr_mem", {27'b0, RegWriteAddr_mem}, 32'd5);
    chk("pass_we_mem", {31'b0, RegWrite_mem}, 32'd1);
    idle(); step();
    chk("pass_wb_data", RegWriteData_wb, 32'h1234);
    chk("pass_wb_addr", {27'b0, RegWriteAddr_wb}, 32'd5);
    chk("pass_wb_we", {31'b0, RegWrite_wb}, 32'd1);

    // sw then lw same address back to back
    drv(32'h10, 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0); step();
    chk("sw_misalign", {31'b0, MisAlign}, 32'd0);
    drv(32'h10, 32'h0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0); step();
    chk("lw_m2r_mem", {31'b0, MemToReg_mem}, 32'd1);
    idle(); step();
    chk("lw_data", RegWriteData_wb, 32'hDEAD_BEEF);
    chk("lw_we", {31'b0, RegWrite_wb}, 32'd1);
    chk("lw_addr", {27'b0, RegWriteAddr_wb}, 32'd8);

    // Address wrap: 0x400 aliases word 0
    drv(32'h400, 32'hA5A5_A5A5, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0); step();
    load_chk("wrap", 32'h0, 5'd9, 32'hA5A5_A5A5);

    // Misaligned sw to 0x13 must not touch word 4
    drv(32'h13, 32'h1234_5678, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0); step();
    chk("mis_sw_flag", {31'b0, MisAlign}, 32'd1);
    load_chk("mis_sw_keep", 32'h10, 5'd3, 32'hDEAD_BEEF);

    // Misaligned lw from 0x22 must not write back
    drv(32'h22, 32'h0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0); step();
    chk("mis_lw_flag", {31'b0, MisAlign}, 32'd1);
    idle(); step();
    chk("mis_lw_we", {31'b0, RegWrite_wb}, 32'd0);
    chk("mis_lw_addr", {27'b0, RegWriteAddr_wb}, 32'd4);

    // Flush turns a store into a bubble
    drv(32'h10, 32'hFFFF_0000, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1); step();
    chk("flush_we_mem", {31'b0, RegWrite_mem}, 32'd0);
    chk("flush_alu_mem", ALUResult_mem, 32'h0);
    chk("flush_addr_mem", {27'b0, RegWriteAddr_mem}, 32'd0);
    chk("flush_misalign", {31'b0, MisAlign}, 32'd0);
    load_chk("flush_keep", 32'h10, 5'd2, 32'hDEAD_BEEF);

    // Two stores to the same word: later wins
    drv(32'h20, 32'h1111_1111, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0); step();
    drv(32'h20, 32'h2222_2222, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0); step();
    load_chk("sw_sw", 32'h20, 5'd6, 32'h2222_2222);

    // Mid-run async reset with a store still in MEM
    drv(32'h55, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0); step();
    drv(32'h10, 32'h0BAD_F00D, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0); step();
    chk("pre_rst_alu_mem", ALUResult_mem, 32'h10);
    chk("pre_rst_wb_data", RegWriteData_wb, 32'h55);
    #2 rst = 1'b1;
    #1;
    chk("arst_alu_mem", ALUResult_mem, 32'h0);
    chk("arst_wb_data", RegWriteData_wb, 32'h0);
    chk("arst_addrs", {22'b0, RegWriteAddr_mem, RegWriteAddr_wb}, 32'h0);
    chk("arst_flags", {28'b0, RegWrite_mem, MemToReg_mem, RegWrite_wb, MisAlign}, 32'h0);
    idle();
    step();
    @(negedge clk); rst = 1'b0;
    load_chk("arst_drop", 32'h10, 5'd1, 32'hDEAD_BEEF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
